histo_sequencer: RTL and testbench

HISTO_SEQUENCER -- requirements
Module: histo_sequencer

---
 rtl/histo_sequencer_pkg.sv | 24 ++
 rtl/histo_sequencer_rmw.sv | 61 ++++++
 rtl/histo_sequencer.sv | 177 +++++++++++++++++
 tb/tb_histo_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/histo_sequencer_pkg.sv
// rtl/histo_sequencer_pkg.sv - shared state type, default sizes and saturating increment for the histogram sequencer
package histo_sequencer_pkg;

   localparam int DEF_NUM_BINS = 1024;
   localparam int DEF_BIN_W    = 10;
   localparam int DEF_CNT_W    = 24;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_ARMED,
      ST_ACCUM,
      ST_DRAIN,
      ST_READOUT
   } state_e;

   // Increment that sticks at the all-ones value of a width-bit counter (width 1..32).
   function automatic logic [31:0] sat_inc(input logic [31:0] val, input int width);
      logic [31:0] max_v;
      max_v = 32'hFFFF_FFFF >> (32 - width);
      return (val >= max_v) ? max_v : val + 32'd1;
   endfunction

endpackage

// File: rtl/histo_sequencer_rmw.sv
// rtl/histo_sequencer_rmw.sv - two-stage read-modify-write of histogram bins with write-to-read forwarding
module histo_rmw_pipe
   import histo_sequencer_pkg::*;
#(
   parameter int BIN_W = DEF_BIN_W,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [BIN_W-1:0] in_pixel,
   output logic [BIN_W-1:0] rd_addr,
   input  logic [CNT_W-1:0] rd_data,
   output logic             wr_en,
   output logic [BIN_W-1:0] wr_addr,
   output logic [CNT_W-1:0] wr_data
);

   logic             s1_valid_q, s1_valid_d;
   logic [BIN_W-1:0] s1_addr_q, s1_addr_d;
   logic             fwd_valid_q, fwd_valid_d;
   logic [BIN_W-1:0] fwd_addr_q, fwd_addr_d;
   logic [CNT_W-1:0] fwd_data_q, fwd_data_d;
   logic [CNT_W-1:0] base;
   logic [CNT_W-1:0] base_inc;

   always_comb begin
      s1_valid_d = in_valid;
      s1_addr_d  = in_valid ? in_pixel : '0;
      rd_addr    = s1_addr_d;

      // The RAM read misses a write committed on the same edge, so take last cycle's write instead.
      base     = (fwd_valid_q && (fwd_addr_q == s1_addr_q)) ? fwd_data_q : rd_data;
      base_inc = CNT_W'(sat_inc(32'(base), CNT_W));

      wr_en   = s1_valid_q;
      wr_addr = s1_valid_q ? s1_addr_q : '0;
      wr_data = s1_valid_q ? base_inc : '0;

      fwd_valid_d = s1_valid_q;
      fwd_addr_d  = wr_addr;
      fwd_data_d  = wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_addr_q   <= '0;
         fwd_valid_q <= 1'b0;
         fwd_addr_q  <= '0;
         fwd_data_q  <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_addr_q   <= s1_addr_d;
         fwd_valid_q <= fwd_valid_d;
         fwd_addr_q  <= fwd_addr_d;
         fwd_data_q  <= fwd_data_d;
      end
   end

endmodule

// File: rtl/histo_sequencer.sv
// rtl/histo_sequencer.sv - histogram sequencer: clears the bin RAM, accumulates one frame, streams the bins out
module histo_sequencer
   import histo_sequencer_pkg::*;
#(
   parameter int NUM_BINS = DEF_NUM_BINS,
   parameter int BIN_W    = DEF_BIN_W,
   parameter int CNT_W    = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             frame_start,
   input  logic             frame_end,
   input  logic [BIN_W-1:0] pixel,
   input  logic             pixel_valid,
   output logic [BIN_W-1:0] ram_rd_addr,
   input  logic [CNT_W-1:0] ram_rd_data,
   output logic             ram_wr_en,
   output logic [BIN_W-1:0] ram_wr_addr,
   output logic [CNT_W-1:0] ram_wr_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [BIN_W-1:0] out_bin,
   output logic [CNT_W-1:0] out_data,
   output logic             out_last,
   output logic             busy,
   output logic             histo_done,
   output logic [31:0]      pixel_count
);

   localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NUM_BINS - 1);
   localparam logic [BIN_W:0]   BIN_END  = (BIN_W + 1)'(NUM_BINS);

   state_e           state_q, state_d;
   logic [BIN_W-1:0] clr_addr_q, clr_addr_d;
   logic             drain_q, drain_d;
   logic [BIN_W:0]   rd_idx_q, rd_idx_d;
   logic             out_valid_q, out_valid_d;
   logic [BIN_W-1:0] out_bin_q, out_bin_d;
   logic             out_last_q, out_last_d;
   logic             done_q, done_d;
   logic [31:0]      pix_cnt_q, pix_cnt_d;

   logic             acc_valid;
   logic             issue;
   logic             beat_acc;
   logic [BIN_W-1:0] pipe_rd_addr;
   logic             pipe_wr_en;
   logic [BIN_W-1:0] pipe_wr_addr;
   logic [CNT_W-1:0] pipe_wr_data;

   // A pixel is taken in ACCUM, or in ARMED when it rides along with frame_start.
   assign acc_valid = pixel_valid && !abort &&
                      ((state_q == ST_ACCUM) || ((state_q == ST_ARMED) && frame_start));

   histo_rmw_pipe #(
      .BIN_W (BIN_W),
      .CNT_W (CNT_W)
   ) u_rmw (
      .clk      (clk),
      .rst_n    (rst),
      .in_valid (acc_valid),
      .in_pixel (pixel),
      .rd_addr  (pipe_rd_addr),
      .rd_data  (ram_rd_data),
      .wr_en    (pipe_wr_en),
      .wr_addr  (pipe_wr_addr),
      .wr_data  (pipe_wr_data)
   );

   always_comb begin
      state_d     = state_q;
      clr_addr_d  = '0;
      drain_d     = 1'b0;
      rd_idx_d    = '0;
      out_valid_d = 1'b0;
      out_bin_d   = out_bin_q;
      out_last_d  = out_last_q;
      done_d      = 1'b0;
      pix_cnt_d   = pix_cnt_q;
      issue       = 1'b0;
      beat_acc    = out_valid_q && out_ready;
      ram_rd_addr = pipe_rd_addr;
      ram_wr_en   = pipe_wr_en;
      ram_wr_addr = pipe_wr_addr;
      ram_wr_data = pipe_wr_data;

      case (state_q)
         ST_IDLE: begin
            if (start && !abort) state_d = ST_CLEAR;
         end
         ST_CLEAR: begin
            ram_wr_en   = 1'b1;
            ram_wr_addr = clr_addr_q;
            ram_wr_data = '0;
            clr_addr_d  = clr_addr_q + BIN_W'(1);
            if (clr_addr_q == LAST_BIN) begin
               state_d   = ST_ARMED;
               pix_cnt_d = '0;
            end
         end
         ST_ARMED: begin
            if (frame_start) state_d = ST_ACCUM;
         end
         ST_ACCUM: begin
            if (frame_end) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            drain_d = 1'b1;
            if (drain_q) state_d = ST_READOUT;
         end
         ST_READOUT: begin
            rd_idx_d    = rd_idx_q;
            out_valid_d = out_valid_q;
            // Only fetch when the output register is free next cycle; a stalled beat keeps re-reading its bin.
            issue = (rd_idx_q != BIN_END) && (!out_valid_q || out_ready);
            if (issue) begin
               ram_rd_addr = rd_idx_q[BIN_W-1:0];
               rd_idx_d    = rd_idx_q + (BIN_W + 1)'(1);
               out_valid_d = 1'b1;
               out_bin_d   = rd_idx_q[BIN_W-1:0];
               out_last_d  = (rd_idx_q[BIN_W-1:0] == LAST_BIN);
            end else begin
               ram_rd_addr = out_bin_q;
               if (beat_acc) out_valid_d = 1'b0;
            end
            if (beat_acc && out_last_q) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (acc_valid) pix_cnt_d = sat_inc(pix_cnt_q, 32);

      if ((state_q != ST_IDLE) && abort) begin
         state_d     = ST_IDLE;
         out_valid_d = 1'b0;
         done_d      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         clr_addr_q  <= '0;
         drain_q     <= 1'b0;
         rd_idx_q    <= '0;
         out_valid_q <= 1'b0;
         out_bin_q   <= '0;
         out_last_q  <= 1'b0;
         done_q      <= 1'b0;
         pix_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         clr_addr_q  <= clr_addr_d;
         drain_q     <= drain_d;
         rd_idx_q    <= rd_idx_d;
         out_valid_q <= out_valid_d;
         out_bin_q   <= out_bin_d;
         out_last_q  <= out_last_d;
         done_q      <= done_d;
         pix_cnt_q   <= pix_cnt_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_bin     = out_bin_q;
   assign out_data    = out_valid_q ? ram_rd_data : '0;
   assign out_last    = out_last_q;
   assign busy        = (state_q != ST_IDLE);
   assign histo_done  = done_q;
   assign pixel_count = pix_cnt_q;

endmodule

// File: tb/tb_histo_sequencer.sv
// tb/tb_histo_sequencer.sv - self-checking bench for histo_sequencer with a histogram model and RAM model
module tb_histo_sequencer;

   localparam int NB   = 1024;
   localparam int BW   = 10;
   localparam int CW   = 24;
   localparam int MAXC = 16777215;

   logic          clk = 1'b0;
   logic          rst, start, abort, frame_start, frame_end, pixel_valid, out_ready;
   logic [BW-1:0] pixel, ram_rd_addr, ram_wr_addr, out_bin;
   logic [CW-1:0] ram_rd_data, ram_wr_data, out_data;
   logic          ram_wr_en, out_valid, out_last, busy, histo_done;
   logic [31:0]   pixel_count;

   logic          pre_en;
   logic [BW-1:0] pre_addr;
   logic [CW-1:0] pre_data;
   logic [CW-1:0] mem [0:NB-1];

   int exp_hist [NB];
   int got_hist [NB];
   int exp_pix;
   int frame_q[$];

   int checks = 0;
   int failures = 0;
   int beat_idx = 0, acc_total = 0, done_cnt = 0, cyc = 0;
   int first_acc_cyc = 0, last_acc_cyc = 0;
   logic          stall_prev = 1'b0, last_acc_prev = 1'b0;
   logic [BW-1:0] held_bin;
   logic [CW-1:0] held_data;
   logic          held_last;

   always #5 clk = ~clk;

   histo_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .abort       (abort),
      .frame_start (frame_start),
      .frame_end   (frame_end),
      .pixel       (pixel),
      .pixel_valid (pixel_valid),
      .ram_rd_addr (ram_rd_addr),
      .ram_rd_data (ram_rd_data),
      .ram_wr_en   (ram_wr_en),
      .ram_wr_addr (ram_wr_addr),
      .ram_wr_data (ram_wr_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_bin     (out_bin),
      .out_data    (out_data),
      .out_last    (out_last),
      .busy        (busy),
      .histo_done  (histo_done),
      .pixel_count (pixel_count)
   );

   // Simple dual-port RAM: registered read returns the contents before this edge's write.
   always @(posedge clk) begin
      ram_rd_data <= mem[ram_rd_addr];
      if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
      if (pre_en) mem[pre_addr] <= pre_data;
   end

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         if (ram_wr_en) check("wr_only_busy", busy, 1);
         check("done_timing", histo_done, last_acc_prev);
         last_acc_prev = 1'b0;
         if (out_valid) begin
            if (stall_prev) begin
               check("stall_bin", out_bin, held_bin);
               check("stall_data", out_data, held_data);
               check("stall_last", out_last, held_last);
            end
            if (out_ready) begin
               check("beat_bin", out_bin, beat_idx);
               check("beat_data", out_data, exp_hist[beat_idx]);
               check("beat_last", out_last, beat_idx == NB - 1);
               got_hist[out_bin] = out_data;
               if (beat_idx == 0) first_acc_cyc = cyc;
               acc_total++;
               if (beat_idx == NB - 1) begin
                  last_acc_cyc  = cyc;
                  last_acc_prev = 1'b1;
                  beat_idx      = 0;
               end else begin
                  beat_idx++;
               end
            end
         end
         stall_prev = out_valid && !out_ready;
         held_bin   = out_bin;
         held_data  = out_data;
         held_last  = out_last;
         if (histo_done) done_cnt++;
      end else begin
         stall_prev    = 1'b0;
         last_acc_prev = 1'b0;
         beat_idx      = 0;
      end
   end

   task automatic check_zero_outputs(input string tag);
      check({tag, "_ram"}, {ram_rd_addr, ram_wr_en, ram_wr_addr, ram_wr_data}, 0);
      check({tag, "_out"}, {out_valid, out_bin, out_data, out_last}, 0);
      check({tag, "_status"}, {busy, histo_done, pixel_count}, 0);
   endtask

   task automatic count_pixel(input int p);
      exp_hist[p] = (exp_hist[p] >= MAXC) ? MAXC : exp_hist[p] + 1;
      exp_pix++;
   endtask

   task automatic do_start();
      tick(); start = 1'b1;
      tick(); start = 1'b0;
      for (int i = 0; i < NB; i++) exp_hist[i] = 0;
      exp_pix = 0;
      repeat (NB - 1) tick();
      check("clear_last_wr", {ram_wr_en, ram_wr_addr, ram_wr_data}, {1'b1, 10'd1023, 24'd0});
      tick();
      check("armed_busy", busy, 1);
      check("armed_no_wr", ram_wr_en, 0);
      check("armed_pixcnt", pixel_count, 0);
   endtask

   task automatic feed();
      tick(); pixel_valid = 1'b1; pixel = BW'(frame_q[0]);
      for (int i = 0; i < frame_q.size(); i++) begin
         tick();
         frame_start = (i == 0);
         frame_end   = (i == frame_q.size() - 1);
         pixel_valid = 1'b1;
         pixel       = BW'(frame_q[i]);
         count_pixel(frame_q[i]);
      end
      tick(); frame_start = 1'b0; frame_end = 1'b0; pixel_valid = 1'b1; pixel = BW'(frame_q[0]);
      tick(); pixel_valid = 1'b0;
      tick();
      check("pixel_count", pixel_count, exp_pix);
   endtask

   task automatic readout(input int mode);
      int   d0, a0, stall_left, n;
      logic tog;
      d0 = done_cnt; a0 = acc_total; stall_left = 20; tog = 1'b1; n = 0;
      for (int i = 0; i < NB; i++) got_hist[i] = -1;
      while (done_cnt == d0 && n < 5000) begin
         tick(); n++;
         if (mode == 0) begin
            out_ready = 1'b1;
         end else if (out_valid && out_bin == 10'd512 && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
         end else begin
            out_ready = tog;
            tog = !tog;
         end
      end
      out_ready = 1'b0;
      check("readout_done_seen", done_cnt != d0, 1);
      repeat (3) tick();
      check("done_once", done_cnt - d0, 1);
      check("beats", acc_total - a0, NB);
      check("idle_after_readout", busy, 0);
      if (mode == 0) check("throughput", last_acc_cyc - first_acc_cyc, NB - 1);
      else check("stall_applied", stall_left, 0);
   endtask

   initial begin
      int nz;
      int found;
      rst = 1'b0; start = 1'b0; abort = 1'b0; frame_start = 1'b0; frame_end = 1'b0;
      pixel_valid = 1'b0; pixel = '0; out_ready = 1'b0;
      pre_en = 1'b0; pre_addr = '0; pre_data = '0;

      for (int i = 0; i < NB; i++) begin
         tick(); pre_en = 1'b1; pre_addr = BW'(i); pre_data = CW'(i * 37 + 11);
      end
      tick(); pre_en = 1'b0;
      check_zero_outputs("reset");
      tick(); rst = 1'b1;
      tick();
      check("idle_after_reset", busy, 0);

      // Ten identical pixels: bin 5 only.
      do_start();
      frame_q.delete();
      for (int i = 0; i < 10; i++) frame_q.push_back(5);
      feed();
      readout(0);
      check("t1_bin5", got_hist[5], 10);
      nz = 0;
      for (int i = 0; i < NB; i++) if (i != 5 && got_hist[i] != 0) nz++;
      check("t1_other_bins_zero", nz, 0);
      check("t1_pixel_count", pixel_count, 10);

      // Back-to-back equal pixels, stalled and toggled readout; start in ARMED is ignored.
      do_start();
      tick(); start = 1'b1;
      tick(); start = 1'b0;
      check("start_ignored_busy", busy, 1);
      check("start_ignored_no_clear", ram_wr_en, 0);
      frame_q = '{3, 3, 7, 3};
      feed();
      readout(1);
      check("t2_bin3", got_hist[3], 3);
      check("t2_bin7", got_hist[7], 1);
      check("t2_pixel_count", pixel_count, 4);

      // Saturation from a preloaded near-full bin.
      do_start();
      tick(); pre_en = 1'b1; pre_addr = 10'd9; pre_data = CW'(MAXC - 1);
      tick(); pre_en = 1'b0;
      exp_hist[9] = MAXC - 1;
      frame_q = '{9, 600, 9, 900, 9};
      feed();
      readout(0);
      check("t3_bin9_sat", got_hist[9], 16777215);
      check("t3_bin600", got_hist[600], 1);
      check("t3_bin900", got_hist[900], 1);

      // Abort partway through CLEAR, then abort+start in IDLE, then a full rerun.
      tick(); start = 1'b1;
      tick(); start = 1'b0;
      found = 0;
      for (int n = 0; n < 2000; n++) begin
         if (ram_wr_en && ram_wr_addr == 10'd300) begin
            found = 1;
            break;
         end
         tick();
      end
      check("abort_point_found", found, 1);
      abort = 1'b1;
      tick(); abort = 1'b0;
      check("abort_idle", busy, 0);
      check("abort_no_wr", ram_wr_en, 0);
      check("abort_no_valid", out_valid, 0);
      start = 1'b1; abort = 1'b1;
      tick(); start = 1'b0; abort = 1'b0;
      check("abort_start_idle", busy, 0);
      tick();
      check("abort_start_still_idle", busy, 0);
      do_start();
      frame_q = '{1, 2, 1};
      feed();
      readout(0);
      check("t4_bin600_cleared", got_hist[600], 0);
      check("t4_bin900_cleared", got_hist[900], 0);
      check("t4_bin9_cleared", got_hist[9], 0);
      check("t4_bin1", got_hist[1], 2);
      check("t4_bin2", got_hist[2], 1);

      // Reset asserted mid-ACCUM.
      do_start();
      tick(); frame_start = 1'b1; pixel_valid = 1'b1; pixel = 10'd10;
      tick(); frame_start = 1'b0; pixel = 10'd11;
      tick(); pixel = 10'd12;
      rst = 1'b0;
      #1;
      check_zero_outputs("midrst");
      tick(); pixel_valid = 1'b0;
      tick(); rst = 1'b1;
      repeat (5) tick();
      check("busy_after_rst", busy, 0);
      check("pixcnt_after_rst", pixel_count, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
